as_imem_loader: RTL and testbench

Parametrised instruction-memory load engine between the JTAG TAP's I-Mem data register and the instruction memory write/read port. It takes scan update words that have already been synchronised into the `clk_i` domain and buffers them in a small FIFO. It then executes single writes, auto-incrementing burst writes, pointer loads and read-backs. It also owns the core reset, so the processor is held in reset while a program is loaded and released under JTAG command.

---
 rtl/as_imem_loader.sv | 157 +++++++++++++++
 tb/tb_as_imem_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/as_imem_loader.sv
// JTAG I-Mem load engine: buffers synchronised scan update words in a small FIFO
// and executes writes, burst writes, pointer loads and read-backs; owns core reset.
module as_imem_loader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       upd_valid_i,
    input  logic [3+ADDR_W+DATA_W-1:0] upd_word_i,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic                       mem_we_o,
    output logic                       mem_re_o,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    output logic                       core_rst_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       rdata_valid_o,
    output logic                       busy_o,
    output logic [2:0]                 err_o,
    output logic [31:0]                chk_o,
    output logic [15:0]                wr_cnt_o
);
    localparam int W    = 3 + ADDR_W + DATA_W;
    localparam int STEP = DATA_W / 8;
    localparam int FAW  = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(READ_LAT + 1);

    localparam logic [2:0] OP_NOP = 3'b000, OP_WRITE = 3'b001, OP_WRITE_INC = 3'b010,
                           OP_SET_PTR = 3'b011, OP_READ = 3'b100, OP_HOLD = 3'b101,
                           OP_RELEASE = 3'b110, OP_CLR_ERR = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_RWAIT = 2'd2;

    logic [FIFO_DEPTH-1:0][W-1:0] fifo;
    logic [FAW:0]                 wr_ptr, rd_ptr;
    logic                         fifo_empty, fifo_full, push, pop, ovf;

    logic [1:0]        state;
    logic [W-1:0]      cmd;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr, ptr;
    logic [DATA_W-1:0] cmd_data;
    logic [CW-1:0]     rcnt;
    logic              is_exec, mis, wr_op, wr_ok, re_ok, err_clr;
    logic [2:0]        err_set;

    // Full when the pointers differ only in the wrap bit.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr == {~rd_ptr[FAW], rd_ptr[FAW-1:0]});
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign push       = upd_valid_i && (!fifo_full || pop);
    assign ovf        = upd_valid_i && !push;

    always_ff @(posedge clk_i) begin
        if (push) fifo[wr_ptr[FAW-1:0]] <= upd_word_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign cmd_op   = cmd[W-1 -: 3];
    assign cmd_addr = cmd[DATA_W +: ADDR_W];
    assign cmd_data = cmd[DATA_W-1:0];

    assign is_exec = (state == S_EXEC);
    assign mis     = |(cmd_addr & ADDR_W'(STEP - 1));
    assign wr_op   = (cmd_op == OP_WRITE) || (cmd_op == OP_WRITE_INC);
    assign wr_ok   = is_exec && core_rst_o &&
                     (((cmd_op == OP_WRITE) && !mis) || (cmd_op == OP_WRITE_INC));
    assign re_ok   = is_exec && (cmd_op == OP_READ) && !mis;

    assign mem_we_o    = wr_ok;
    assign mem_re_o    = re_ok;
    assign mem_addr_o  = (cmd_op == OP_WRITE_INC) ? ptr : cmd_addr;
    assign mem_wdata_o = cmd_data;
    assign busy_o      = !fifo_empty || (state != S_IDLE);

    always_comb begin
        err_set    = 3'b000;
        err_set[0] = ovf;
        err_set[1] = is_exec && mis &&
                     ((cmd_op == OP_WRITE) || (cmd_op == OP_SET_PTR) || (cmd_op == OP_READ));
        err_set[2] = is_exec && wr_op && !core_rst_o;
        err_clr    = is_exec && (cmd_op == OP_CLR_ERR);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            cmd           <= '0;
            ptr           <= '0;
            core_rst_o    <= 1'b1;
            err_o         <= '0;
            chk_o         <= '0;
            wr_cnt_o      <= '0;
            rcnt          <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
        end else begin
            rdata_valid_o <= 1'b0;
            // A new overflow in the clearing cycle survives the clear.
            err_o <= (err_clr ? 3'b000 : err_o) | err_set;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cmd   <= fifo[rd_ptr[FAW-1:0]];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_IDLE;
                    if (wr_ok) begin
                        chk_o <= chk_o + cmd_data[31:0];
                        if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
                    end
                    case (cmd_op)
                        OP_WRITE_INC: if (wr_ok) ptr <= ptr + ADDR_W'(STEP);
                        OP_SET_PTR:   if (!mis) ptr <= cmd_addr;
                        OP_READ: begin
                            if (!mis) begin
                                state <= S_RWAIT;
                                rcnt  <= '0;
                            end
                        end
                        OP_HOLD: begin
                            core_rst_o <= 1'b1;
                            chk_o      <= '0;
                            wr_cnt_o   <= '0;
                        end
                        OP_RELEASE: core_rst_o <= 1'b0;
                        default: ;
                    endcase
                end
                S_RWAIT: begin
                    if (rcnt == CW'(READ_LAT - 1)) begin
                        rdata_o       <= mem_rdata_i;
                        rdata_valid_o <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        rcnt <= rcnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_as_imem_loader.sv
// Directed bench for as_imem_loader: expected strobes/read-backs queued at stimulus time,
// popped and compared by a monitor when the DUT produces them.
module tb_as_imem_loader;
    localparam int ADDR_W = 10, DATA_W = 32, W = 3 + ADDR_W + DATA_W;
    localparam logic [2:0] WR = 3'b001, WI = 3'b010, SP = 3'b011, RD = 3'b100,
                           HOLD = 3'b101, REL = 3'b110, CLR = 3'b111;

    logic clk = 1'b0, rst = 1'b1, upd_valid = 1'b0;
    logic [W-1:0] upd_word = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata = '0, rdata;
    logic mem_we, mem_re, core_rst, rdata_valid, busy;
    logic [2:0] err;
    logic [31:0] chk;
    logic [15:0] wr_cnt;

    int checks = 0, errors = 0, we_cnt = 0;
    logic [ADDR_W-1:0] wq_a[$], rq_a[$];
    logic [31:0] wq_d[$], rq_d[$];
    logic [31:0] mem_model [256];

    as_imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .READ_LAT(1)) dut (
        .clk_i(clk), .rst_i(rst), .upd_valid_i(upd_valid), .upd_word_i(upd_word),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_re_o(mem_re),
        .mem_rdata_i(mem_rdata), .core_rst_o(core_rst), .rdata_o(rdata),
        .rdata_valid_o(rdata_valid), .busy_o(busy), .err_o(err), .chk_o(chk), .wr_cnt_o(wr_cnt)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_model[mem_addr[9:2]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                we_cnt++;
                check("we_expected", 64'(wq_a.size() != 0), 64'd1);
                if (wq_a.size() != 0) begin
                    check("we_addr", 64'(mem_addr), 64'(wq_a.pop_front()));
                    check("we_data", 64'(mem_wdata), 64'(wq_d.pop_front()));
                end
            end
            if (mem_re) begin
                check("re_expected", 64'(rq_a.size() != 0), 64'd1);
                if (rq_a.size() != 0) check("re_addr", 64'(mem_addr), 64'(rq_a.pop_front()));
            end
            if (rdata_valid) begin
                check("rdv_expected", 64'(rq_d.size() != 0), 64'd1);
                if (rq_d.size() != 0) check("rdata", 64'(rdata), 64'(rq_d.pop_front()));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        upd_valid = 1'b1;
        upd_word  = {op, a, d};
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wq_a.push_back(a);
        wq_d.push_back(d);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || wq_a.size() != 0 || rq_d.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 64'(n < 100), 64'd1);
    endtask

    initial begin
        int snap;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_chk", chk, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_we", mem_we, 0);
        rst = 1'b0;

        // Single write with cycle-exact strobe
        exp_wr(10'h004, 32'h01D00513);
        send(WR, 10'h004, 32'h01D00513);
        check("we_c1", mem_we, 0);
        @(posedge clk); #1;
        check("we_c2", mem_we, 1);
        check("we_c2_addr", mem_addr, 10'h004);
        @(posedge clk); #1;
        check("we_c3", mem_we, 0);
        drain();
        check("single_chk", chk, 32'h01D00513);
        check("single_cnt", wr_cnt, 1);

        send(HOLD, '0, '0);
        drain();
        check("hold_chk", chk, 0);
        check("hold_cnt", wr_cnt, 0);

        // Burst wrapping past the top of the address space
        exp_wr(10'h3FC, 32'hAAAAAAAA);
        exp_wr(10'h000, 32'h55555555);
        send(SP, 10'h3FC, '0);
        send(WI, 10'h123, 32'hAAAAAAAA);
        send(WI, 10'h000, 32'h55555555);
        drain();
        check("burst_chk", chk, 32'hFFFFFFFF);
        check("burst_cnt", wr_cnt, 2);

        // Read-back
        rq_a.push_back(10'h004);
        rq_d.push_back(32'h01D00513);
        send(RD, 10'h004, '0);
        @(posedge clk); #1;
        check("re_c2", mem_re, 1);
        @(posedge clk); #1;
        check("rdv_c3", rdata_valid, 0);
        @(posedge clk); #1;
        check("rdv_c4", rdata_valid, 1);
        check("rdata_c4", rdata, 32'h01D00513);
        drain();

        // Misaligned write dropped
        snap = we_cnt;
        send(WR, 10'h006, 32'hDEADBEEF);
        drain();
        check("mis_err", err[1], 1);
        check("mis_no_we", we_cnt, snap);
        check("mis_cnt", wr_cnt, 2);

        // Write while core runs
        send(REL, '0, '0);
        send(WR, 10'h000, 32'h12345678);
        drain();
        check("rel_core", core_rst, 0);
        check("run_err", err[2], 1);
        check("run_no_we", we_cnt, snap);
        send(CLR, '0, '0);
        drain();
        check("clr_err", err, 0);
        send(HOLD, '0, '0);
        drain();
        check("hold2_core", core_rst, 1);
        check("hold2_chk", chk, 0);

        // Overflow: 9 back-to-back pushes into a depth-4 FIFO
        we_cnt = 0;
        for (int i = 0; i < 8; i++) exp_wr(10'(10'h100 + 4 * i), 32'(32'hC000 + i));
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            upd_valid = 1'b1;
            upd_word  = {WR, 10'(10'h100 + 4 * i), 32'(32'hC000 + i)};
            @(posedge clk); #1;
        end
        upd_valid = 1'b0;
        check("ovf_err", err[0], 1);
        drain();
        check("ovf_we_cnt", we_cnt, 8);
        check("ovf_wr_cnt", wr_cnt, 8);

        // Reset asserted during a burst strobe
        for (int i = 0; i < 4; i++) exp_wr(10'(10'h200 + 4 * i), 32'(32'hD000 + i));
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1;
            upd_word  = {WR, 10'(10'h200 + 4 * i), 32'(32'hD000 + i)};
            @(posedge clk); #1;
        end
        upd_valid = 1'b0;
        n = 0;
        while (!mem_we && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_we_seen", 64'(n < 20), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_core", core_rst, 1);
        wq_a.delete();
        wq_d.delete();
        snap = we_cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_we", we_cnt, snap);
        check("post_rst_cnt", wr_cnt, 0);
        check("post_rst_err", err, 0);
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
